mdr_mem_if: RTL and testbench

Parametrised memory data register (MDR) with a built-in memory transaction sequencer for the Mini-SRC datapath.
- Holds the word exchanged between the internal bus and memory.
- Runs a req/ack handshake for reads and writes using the address supplied by the MAR, with a bounded wait-state timeout.
- Sits between the bus mux, the MAR and the memory model. The control unit starts a transfer and waits for done before the next step.

---
 rtl/mdr_pkg.sv | 21 ++
 rtl/mdr_mem_if_if.sv | 44 ++++
 rtl/mdr_wait_timer.sv | 33 +++
 rtl/mdr_mem_if.sv | 120 ++++++++++++
 tb/tb_mdr_mem_if.sv | 246 ++++++++++++++++++++++++
 5 files changed

// File: rtl/mdr_pkg.sv
// -----------------------------------------------------------------------------
// mdr_pkg
// Shared types and constants for the Mini-SRC memory data register block.
//   mdr_state_t    : transaction sequencer states
//   CNT_W          : width of the wait-state counter
//   DEF_*_WIDTH    : default data / address widths
// -----------------------------------------------------------------------------
package mdr_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RD_WAIT,
        WR_WAIT,
        FINISH
    } mdr_state_t;

    localparam int CNT_W          = 8;
    localparam int DEF_DATA_WIDTH = 32;
    localparam int DEF_ADDR_WIDTH = 9;

endpackage

// File: rtl/mdr_mem_if_if.sv
// -----------------------------------------------------------------------------
// mdr_mem_if_if
// Bus/handshake bundle of the MDR block: control-unit and datapath inputs,
// the memory req/ack channel and the status outputs.
//   slave  : view used by mdr_mem_if
//   master : view used by whatever drives the block (control unit, memory)
// -----------------------------------------------------------------------------
interface mdr_mem_if_if
    import mdr_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
);
    logic                  MDRin;
    logic                  read;
    logic [DATA_WIDTH-1:0] BusMuxOut;
    logic [DATA_WIDTH-1:0] Mdatain;
    logic [ADDR_WIDTH-1:0] mar_addr;
    logic                  rd_start;
    logic                  wr_start;
    logic [DATA_WIDTH-1:0] mem_rdata;
    logic                  mem_ack;
    logic                  mem_req;
    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic [DATA_WIDTH-1:0] MDRout;
    logic                  busy;
    logic                  done;
    logic                  err;

    modport slave (
        input  MDRin, read, BusMuxOut, Mdatain, mar_addr, rd_start, wr_start,
               mem_rdata, mem_ack,
        output mem_req, mem_we, mem_addr, mem_wdata, MDRout, busy, done, err
    );

    modport master (
        output MDRin, read, BusMuxOut, Mdatain, mar_addr, rd_start, wr_start,
               mem_rdata, mem_ack,
        input  mem_req, mem_we, mem_addr, mem_wdata, MDRout, busy, done, err
    );

endinterface

// File: rtl/mdr_wait_timer.sv
// -----------------------------------------------------------------------------
// mdr_wait_timer
// Wait-state counter for the memory handshake.
//   clock   : rising-edge clock
//   clear   : synchronous active-high reset
//   cnt_clr : return count to zero (no transaction waiting)
//   en      : count one more wait cycle
//   tc      : count equals TERMINAL
// -----------------------------------------------------------------------------
module mdr_wait_timer #(
    parameter int CNT_W    = 8,
    parameter int TERMINAL = 14
) (
    input  logic clock,
    input  logic clear,
    input  logic cnt_clr,
    input  logic en,
    output logic tc
);
    localparam logic [CNT_W-1:0] TC_VAL = TERMINAL[CNT_W-1:0];

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clock) begin
        if (clear || cnt_clr)
            cnt <= '0;
        else if (en)
            cnt <= cnt + 1'b1;
    end

    assign tc = (cnt == TC_VAL);

endmodule

// File: rtl/mdr_mem_if.sv
// -----------------------------------------------------------------------------
// mdr_mem_if
// Memory data register with a read/write transaction sequencer.
//   clock : rising-edge clock
//   clear : synchronous active-high reset (aborts any transfer silently)
//   bus   : mdr_mem_if_if.slave -- MDR load controls, MAR address, start
//           pulses, memory req/ack channel, MDRout and busy/done/err status
// Build option: define MDR_TIMEOUT_EN to abort a transfer with an err pulse
// when no mem_ack arrives within TIMEOUT wait cycles; without it the
// sequencer waits indefinitely and err stays low.
// -----------------------------------------------------------------------------
module mdr_mem_if
    import mdr_pkg::*;
#(
    parameter int                    DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int                    ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int                    TIMEOUT    = 15,
    parameter logic [DATA_WIDTH-1:0] INIT       = '0
) (
    input  logic        clock,
    input  logic        clear,
    mdr_mem_if_if.slave bus
);
    mdr_state_t            state, state_nxt;
    logic [DATA_WIDTH-1:0] mdr_q, mdr_nxt;
    logic [ADDR_WIDTH-1:0] addr_q, addr_nxt;
    logic                  err_q, err_nxt;
    logic                  waiting;
    logic                  timed_out;

    assign waiting = (state == RD_WAIT) || (state == WR_WAIT);

`ifdef MDR_TIMEOUT_EN
    logic tc;

    // tc flags the last allowed wait cycle; an ack in that same cycle
    // still wins, so the abort is qualified with !mem_ack.
    mdr_wait_timer #(
        .CNT_W    (CNT_W),
        .TERMINAL (TIMEOUT - 1)
    ) u_timer (
        .clock   (clock),
        .clear   (clear),
        .cnt_clr (!waiting),
        .en      (waiting && !bus.mem_ack),
        .tc      (tc)
    );

    assign timed_out = tc && !bus.mem_ack;
`else
    localparam int timeout_unused = TIMEOUT;
    assign timed_out = 1'b0;
`endif

    always_comb begin
        state_nxt = state;
        mdr_nxt   = mdr_q;
        addr_nxt  = addr_q;
        err_nxt   = 1'b0;
        case (state)
            IDLE: begin
                // read beats write, and any start beats a direct MDR load
                if (bus.rd_start) begin
                    addr_nxt  = bus.mar_addr;
                    state_nxt = RD_WAIT;
                end else if (bus.wr_start) begin
                    addr_nxt  = bus.mar_addr;
                    state_nxt = WR_WAIT;
                end else if (bus.MDRin) begin
                    mdr_nxt = bus.read ? bus.Mdatain : bus.BusMuxOut;
                end
            end
            RD_WAIT: begin
                if (bus.mem_ack) begin
                    mdr_nxt   = bus.mem_rdata;
                    state_nxt = FINISH;
                end else if (timed_out) begin
                    err_nxt   = 1'b1;
                    state_nxt = IDLE;
                end
            end
            WR_WAIT: begin
                if (bus.mem_ack) begin
                    state_nxt = FINISH;
                end else if (timed_out) begin
                    err_nxt   = 1'b1;
                    state_nxt = IDLE;
                end
            end
            FINISH:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (clear) begin
            state  <= IDLE;
            mdr_q  <= INIT;
            addr_q <= '0;
            err_q  <= 1'b0;
        end else begin
            state  <= state_nxt;
            mdr_q  <= mdr_nxt;
            addr_q <= addr_nxt;
            err_q  <= err_nxt;
        end
    end

    // request and direction are pure decodes of the wait states, so they
    // drop in the same cycle the sequencer leaves them
    assign bus.mem_req   = waiting;
    assign bus.mem_we    = (state == WR_WAIT);
    assign bus.mem_addr  = addr_q;
    assign bus.mem_wdata = mdr_q;
    assign bus.MDRout    = mdr_q;
    assign bus.busy      = waiting;
    assign bus.done      = (state == FINISH);
    assign bus.err       = err_q;

endmodule

// File: tb/tb_mdr_mem_if.sv
module tb_mdr_mem_if;
    import mdr_pkg::*;

    localparam int             DW     = 32;
    localparam int             AW     = 9;
    localparam int             TO     = 4;
    localparam logic [DW-1:0]  INIT_V = '0;

    logic clock = 1'b0;
    logic clear = 1'b1;
    always #5 clock = ~clock;

    mdr_mem_if_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

    mdr_mem_if #(
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW),
        .TIMEOUT    (TO),
        .INIT       (INIT_V)
    ) dut (
        .clock (clock),
        .clear (clear),
        .bus   (bus)
    );

    typedef struct {
        bit            is_err;
        logic [DW-1:0] mdr;
        logic [AW-1:0] addr;
        bit            we;
        bit            chk_bus;
        int            lat;
    } exp_t;

    exp_t q[$];
    int   n_checks  = 0;
    int   n_pass    = 0;
    int   cyc       = 0;
    int   start_cyc = 0;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act === req)
            n_pass++;
        else
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // start_cyc is the cycle in which the start pulse was presented
    task automatic mark_start();
        start_cyc = cyc - 1;
    endtask

    // Monitor: snapshot the bus on the ack cycle, compare on done/err.
    logic          snap_we;
    logic [AW-1:0] snap_addr;
    logic [DW-1:0] snap_wdata;

    always @(negedge clock) begin
        exp_t e;
        if (bus.mem_req && bus.mem_ack) begin
            snap_we    = bus.mem_we;
            snap_addr  = bus.mem_addr;
            snap_wdata = bus.mem_wdata;
        end
        if (bus.done || bus.err) begin
            if (q.size() == 0) begin
                chk("unexpected_pulse", {62'd0, bus.done, bus.err}, 64'd0);
            end else begin
                e = q.pop_front();
                chk("pulse_err", bus.err, e.is_err);
                chk("pulse_done", bus.done, !e.is_err);
                chk("MDRout_at_end", bus.MDRout, e.mdr);
                chk("latency", cyc - start_cyc, e.lat);
                if (e.chk_bus) begin
                    chk("mem_addr", snap_addr, e.addr);
                    chk("mem_we", snap_we, e.we);
                    if (e.we) chk("mem_wdata", snap_wdata, e.mdr);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int reqc;
        bus.MDRin     = 1'b0;
        bus.read      = 1'b0;
        bus.BusMuxOut = '0;
        bus.Mdatain   = '0;
        bus.mar_addr  = '0;
        bus.rd_start  = 1'b0;
        bus.wr_start  = 1'b0;
        bus.mem_rdata = '0;
        bus.mem_ack   = 1'b0;
        clear = 1'b1;
        tick();
        tick();
        clear = 1'b0;

        // reset state
        chk("rst_MDRout", bus.MDRout, INIT_V);
        chk("rst_mem_req", bus.mem_req, 0);
        chk("rst_mem_we", bus.mem_we, 0);
        chk("rst_mem_addr", bus.mem_addr, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_done", bus.done, 0);
        chk("rst_err", bus.err, 0);

        // direct loads from bus and from Mdatain
        bus.MDRin = 1'b1; bus.read = 1'b0;
        bus.BusMuxOut = 32'hDEADBEEF; bus.Mdatain = 32'h55555555;
        tick();
        bus.MDRin = 1'b0;
        chk("load_bus", bus.MDRout, 32'hDEADBEEF);
        chk("wdata_follows", bus.mem_wdata, 32'hDEADBEEF);
        bus.MDRin = 1'b1; bus.read = 1'b1; bus.Mdatain = 32'hA5A5A5A5;
        tick();
        bus.MDRin = 1'b0; bus.read = 1'b0;
        chk("load_mdatain", bus.MDRout, 32'hA5A5A5A5);

        // read, ack in third wait cycle; MDRin while busy is ignored
        bus.mar_addr = 9'h0A5; bus.rd_start = 1'b1;
        tick();
        bus.rd_start = 1'b0; mark_start();
        q.push_back('{1'b0, 32'h12345678, 9'h0A5, 1'b0, 1'b1, 4});
        chk("rd_busy", bus.busy, 1);
        chk("rd_req", bus.mem_req, 1);
        chk("rd_we", bus.mem_we, 0);
        chk("rd_addr", bus.mem_addr, 9'h0A5);
        bus.MDRin = 1'b1; bus.BusMuxOut = 32'h0;
        tick();
        chk("rd_mdr_hold", bus.MDRout, 32'hA5A5A5A5);
        tick();
        bus.mem_ack = 1'b1; bus.mem_rdata = 32'h12345678;
        tick();
        bus.mem_ack = 1'b0; bus.MDRin = 1'b0;
        chk("rd_req_drop", bus.mem_req, 0);
        chk("rd_busy_finish", bus.busy, 0);
        tick();
        tick();

        // write with immediate ack; MDR stable during the write
        bus.MDRin = 1'b1; bus.BusMuxOut = 32'hCAFEF00D;
        tick();
        bus.MDRin = 1'b0;
        bus.mar_addr = 9'h1FF; bus.wr_start = 1'b1;
        tick();
        bus.wr_start = 1'b0; mark_start();
        q.push_back('{1'b0, 32'hCAFEF00D, 9'h1FF, 1'b1, 1'b1, 2});
        chk("wr_we", bus.mem_we, 1);
        chk("wr_wdata", bus.mem_wdata, 32'hCAFEF00D);
        bus.MDRin = 1'b1; bus.BusMuxOut = 32'h0; bus.mem_ack = 1'b1;
        tick();
        bus.MDRin = 1'b0; bus.mem_ack = 1'b0;
        tick();
        chk("wr_mdr_kept", bus.MDRout, 32'hCAFEF00D);

        // simultaneous rd_start + wr_start + MDRin: read only
        bus.rd_start = 1'b1; bus.wr_start = 1'b1; bus.MDRin = 1'b1;
        bus.BusMuxOut = 32'h11111111; bus.mar_addr = 9'h033;
        tick();
        bus.rd_start = 1'b0; bus.wr_start = 1'b0; bus.MDRin = 1'b0; mark_start();
        q.push_back('{1'b0, 32'h0BADF00D, 9'h033, 1'b0, 1'b1, 3});
        chk("sim_we", bus.mem_we, 0);
        chk("sim_no_load", bus.MDRout, 32'hCAFEF00D);
        chk("sim_addr", bus.mem_addr, 9'h033);
        tick();
        bus.mem_ack = 1'b1; bus.mem_rdata = 32'h0BADF00D;
        tick();
        bus.mem_ack = 1'b0;
        tick();
        tick();

        // stray ack in IDLE must not start or finish anything
        bus.mem_ack = 1'b1;
        tick();
        tick();
        bus.mem_ack = 1'b0;
        chk("idle_ack_busy", bus.busy, 0);
        chk("idle_ack_mdr", bus.MDRout, 32'h0BADF00D);

`ifdef MDR_TIMEOUT_EN
        // no ack: four wait cycles then err, MDR untouched
        bus.mar_addr = 9'h077; bus.rd_start = 1'b1;
        tick();
        bus.rd_start = 1'b0; mark_start();
        q.push_back('{1'b1, 32'h0BADF00D, 9'h077, 1'b0, 1'b0, 5});
        reqc = 0;
        for (int i = 0; i < 10; i++) begin
            if (bus.mem_req) reqc++;
            tick();
        end
        chk("to_req_cycles", reqc, TO);
        chk("to_busy", bus.busy, 0);
        chk("to_mdr", bus.MDRout, 32'h0BADF00D);

        // ack in the last allowed wait cycle is a success
        bus.rd_start = 1'b1;
        tick();
        bus.rd_start = 1'b0; mark_start();
        q.push_back('{1'b0, 32'h13579BDF, 9'h077, 1'b0, 1'b1, 5});
        tick();
        tick();
        tick();
        bus.mem_ack = 1'b1; bus.mem_rdata = 32'h13579BDF;
        tick();
        bus.mem_ack = 1'b0;
        tick();
        tick();
`endif

        // clear in RD_WAIT with ack the same cycle: silent abort
        bus.mar_addr = 9'h0F0; bus.rd_start = 1'b1;
        tick();
        bus.rd_start = 1'b0;
        clear = 1'b1; bus.mem_ack = 1'b1; bus.mem_rdata = 32'hFFFFFFFF;
        tick();
        clear = 1'b0; bus.mem_ack = 1'b0;
        chk("clr_mdr", bus.MDRout, INIT_V);
        chk("clr_req", bus.mem_req, 0);
        chk("clr_busy", bus.busy, 0);
        chk("clr_addr", bus.mem_addr, 0);
        chk("clr_done", bus.done, 0);
        chk("clr_err", bus.err, 0);
        tick();
        tick();

        chk("scoreboard_drained", q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
